// File: rtl/cf_pkg.sv
// Shared control-flow definitions: opcodes, FSM state encoding and default PC width
// for the CALL/RET unit and future jump/branch blocks.
package cf_pkg;

   localparam int CF_ADDR_W = 19;

   localparam logic CF_OP_CALL = 1'b0;
   localparam logic CF_OP_RET  = 1'b1;

   typedef enum logic [1:0] {
      CF_IDLE = 2'd0,
      CF_RD   = 2'd1,
      CF_RESP = 2'd2
   } cf_state_e;

   // Fall-through address of an instruction; wraps modulo 2^w.
   function automatic logic [31:0] cf_next_pc(input logic [31:0] pc, input int w);
      logic [31:0] mask;
      mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      return (pc + 32'd1) & mask;
   endfunction

endpackage

// File: rtl/call_stack_ram.sv
// Return-address storage: one synchronous write port and one registered read port.
// Contents are not reset.
module call_stack_ram #(
   parameter int ADDR_W = 19,
   parameter int DEPTH  = 256,
   localparam int SP_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [SP_W-1:0]   waddr,
   input  logic [ADDR_W-1:0] wdata,
   input  logic              re,
   input  logic [SP_W-1:0]   raddr,
   output logic [ADDR_W-1:0] rdata
);

   logic [ADDR_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/call_ret_stack.sv
// CALL/RET control-flow unit: downward-growing return-address stack with a
// valid/ready command port, one-cycle response pulse and sticky error flags.
//
// state   | meaning
// --------+----------------------------------------------------------
// CF_IDLE | cmd_ready high, waiting for a command
// CF_RD   | RET accepted, RAM read in flight, data lands this cycle
// CF_RESP | resp_valid high for one cycle, then back to CF_IDLE
module call_ret_stack
   import cf_pkg::*;
#(
   parameter int ADDR_W = CF_ADDR_W,
   parameter int DEPTH  = 256,
   localparam int SP_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [ADDR_W-1:0] cmd_pc,
   output logic              resp_valid,
   output logic [ADDR_W-1:0] resp_pc,
   output logic              resp_err,
   output logic [SP_W-1:0]   sp,
   output logic              full,
   output logic              empty,
   output logic              err_overflow,
   output logic              err_underflow
);

   localparam logic [SP_W-1:0] SP_EMPTY   = SP_W'(DEPTH - 1);
   localparam logic [SP_W:0]   COUNT_FULL = (SP_W + 1)'(DEPTH);

   cf_state_e         state;
   logic [SP_W:0]     count;
   logic [SP_W-1:0]   sp_inc;
   logic [ADDR_W-1:0] ret_addr;
   logic [ADDR_W-1:0] ram_rdata;
   logic              accept;
   logic              do_call;
   logic              do_ret;

   assign full     = (count == COUNT_FULL);
   assign empty    = (count == '0);
   assign sp_inc   = sp + SP_W'(1);
   assign ret_addr = cmd_pc + ADDR_W'(1);

   // cmd_ready is registered and high exactly in CF_IDLE, so it doubles as the idle qualifier.
   assign accept  = cmd_valid & cmd_ready;
   assign do_call = accept & (cmd_op == CF_OP_CALL) & ~full;
   assign do_ret  = accept & (cmd_op == CF_OP_RET) & ~empty;

   // The read is launched at the accepting edge with the post-increment pointer,
   // so the RAM output is stable during CF_RD and captured into resp_pc.
   call_stack_ram #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (do_call),
      .waddr (sp),
      .wdata (ret_addr),
      .re    (do_ret),
      .raddr (sp_inc),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= CF_IDLE;
         sp            <= SP_EMPTY;
         count         <= '0;
         cmd_ready     <= 1'b1;
         resp_valid    <= 1'b0;
         resp_pc       <= '0;
         resp_err      <= 1'b0;
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            CF_IDLE: begin
               if (accept) begin
                  cmd_ready <= 1'b0;
                  if (cmd_op == CF_OP_CALL) begin
                     if (full) begin
                        err_overflow <= 1'b1;
                        resp_err     <= 1'b1;
                        resp_pc      <= ret_addr;
                     end else begin
                        sp       <= sp - SP_W'(1);
                        count    <= count + (SP_W + 1)'(1);
                        resp_err <= 1'b0;
                        resp_pc  <= cmd_addr;
                     end
                     resp_valid <= 1'b1;
                     state      <= CF_RESP;
                  end else begin
                     if (empty) begin
                        err_underflow <= 1'b1;
                        resp_err      <= 1'b1;
                        resp_pc       <= ret_addr;
                        resp_valid    <= 1'b1;
                        state         <= CF_RESP;
                     end else begin
                        sp    <= sp_inc;
                        count <= count - (SP_W + 1)'(1);
                        state <= CF_RD;
                     end
                  end
               end
            end
            CF_RD: begin
               resp_pc    <= ram_rdata;
               resp_err   <= 1'b0;
               resp_valid <= 1'b1;
               state      <= CF_RESP;
            end
            CF_RESP: begin
               cmd_ready <= 1'b1;
               state     <= CF_IDLE;
            end
            default: begin
               cmd_ready <= 1'b1;
               state     <= CF_IDLE;
            end
         endcase
      end
   end

endmodule
